// File: rtl/cic_rate_ctrl.sv
// Run-time rate controller for one CIC decimator: range-checks rate requests,
// sequences flush/load/settle, and gates the CIC output stream to the FIR.
module cic_rate_ctrl #(
  parameter int STAGES             = 5,
  parameter int MIN_DECIMATION     = 2,
  parameter int MAX_DECIMATION     = 40,
  parameter int DEFAULT_DECIMATION = 40,
  parameter int FLUSH_CYCLES       = 4,
  parameter int OUT_WIDTH          = 18,
  parameter int DW                 = $clog2(MAX_DECIMATION) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rate_req,
  input  logic [DW-1:0]        rate_value,
  output logic                 rate_ack,
  output logic                 rate_err,
  output logic [DW-1:0]        decimation,
  output logic                 cic_reset,
  input  logic                 cic_strobe,
  input  logic [OUT_WIDTH-1:0] cic_data,
  output logic                 out_strobe,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 busy
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam int SCW = $clog2(STAGES + 1);

  localparam logic [FCW-1:0] FLUSH_LAST  = FCW'(FLUSH_CYCLES - 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(STAGES);
  localparam logic [DW-1:0]  DEC_MIN     = DW'(MIN_DECIMATION);
  localparam logic [DW-1:0]  DEC_MAX     = DW'(MAX_DECIMATION);
  localparam logic [DW-1:0]  DEC_DEFAULT = DW'(DEFAULT_DECIMATION);

  logic [1:0]     state;
  logic [FCW-1:0] flush_cnt;
  logic [SCW-1:0] settle_cnt;
  logic           pending;
  logic           launch_pend;
  logic [DW-1:0]  launch_value;
  logic           ack_owed;

  logic req_legal;
  logic err_now;
  logic same_rate;
  logic restart;
  logic defer;
  logic settle_done;
  logic ack_want;

  // A legal request colliding with a RUN-state strobe is parked for one cycle
  // so that strobe reaches the output before busy rises.
  always_comb begin
    req_legal   = (rate_value >= DEC_MIN) && (rate_value <= DEC_MAX);
    err_now     = rate_req && !req_legal;
    same_rate   = rate_req && req_legal && (state == ST_RUN) && !launch_pend &&
                  (rate_value == decimation);
    restart     = rate_req && req_legal && !same_rate;
    defer       = restart && (state == ST_RUN) && cic_strobe && !launch_pend;
    settle_done = (state == ST_SETTLE) && cic_strobe && (settle_cnt == SETTLE_LAST);
    ack_want    = same_rate || (settle_done && pending && !restart) || ack_owed;
  end

  assign cic_reset = (state == ST_FLUSH);
  assign busy      = (state != ST_RUN);

  // An ack that would coincide with an error pulse is carried one cycle
  // so the two handshakes never overlap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_FLUSH;
      flush_cnt    <= '0;
      settle_cnt   <= '0;
      decimation   <= DEC_DEFAULT;
      pending      <= 1'b0;
      launch_pend  <= 1'b0;
      launch_value <= '0;
      ack_owed     <= 1'b0;
      rate_ack     <= 1'b0;
      rate_err     <= 1'b0;
      out_strobe   <= 1'b0;
      out_data     <= '0;
    end else begin
      rate_err   <= err_now;
      rate_ack   <= ack_want && !err_now;
      ack_owed   <= ack_want && err_now;
      out_strobe <= 1'b0;

      if ((state == ST_RUN) && cic_strobe && !launch_pend) begin
        out_strobe <= 1'b1;
        out_data   <= cic_data;
      end

      case (state)
        ST_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cic_strobe) begin
            if (settle_cnt == SETTLE_LAST) begin
              state   <= ST_RUN;
              pending <= 1'b0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
        end
        default: begin
          if (launch_pend) begin
            state       <= ST_FLUSH;
            flush_cnt   <= '0;
            decimation  <= launch_value;
            pending     <= 1'b1;
            launch_pend <= 1'b0;
          end
        end
      endcase

      if (defer) begin
        launch_pend  <= 1'b1;
        launch_value <= rate_value;
      end else if (restart) begin
        state       <= ST_FLUSH;
        flush_cnt   <= '0;
        decimation  <= rate_value;
        pending     <= 1'b1;
        launch_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Directed self-checking bench for cic_rate_ctrl; inputs change and outputs
// are sampled on the falling clock edge.
module tb_cic_rate_ctrl;
  localparam int DW = 7;
  localparam int OW = 18;

  logic          clock;
  logic          reset;
  logic          rate_req;
  logic [DW-1:0] rate_value;
  logic          rate_ack;
  logic          rate_err;
  logic [DW-1:0] decimation;
  logic          cic_reset;
  logic          cic_strobe;
  logic [OW-1:0] cic_data;
  logic          out_strobe;
  logic [OW-1:0] out_data;
  logic          busy;

  int n_compared;
  int n_mismatched;
  int ack_seen;

  cic_rate_ctrl dut (
    .clock(clock), .reset(reset), .rate_req(rate_req), .rate_value(rate_value),
    .rate_ack(rate_ack), .rate_err(rate_err), .decimation(decimation),
    .cic_reset(cic_reset), .cic_strobe(cic_strobe), .cic_data(cic_data),
    .out_strobe(out_strobe), .out_data(out_data), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_strobe(input logic [OW-1:0] d);
    cic_strobe = 1'b1;
    cic_data   = d;
    @(negedge clock);
    cic_strobe = 1'b0;
  endtask

  task automatic send_req(input logic [DW-1:0] v, input logic with_strobe, input logic [OW-1:0] d);
    rate_req   = 1'b1;
    rate_value = v;
    cic_strobe = with_strobe;
    cic_data   = d;
    @(negedge clock);
    rate_req   = 1'b0;
    cic_strobe = 1'b0;
  endtask

  // Releases reset and walks the default flush/settle with strobes every 40 clocks.
  task automatic reset_flush_sequence();
    logic exp;
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      exp = (i < 4);
      n_compared++;
      if (cic_reset !== exp) begin n_mismatched++; $display("[TB] FAIL rst_cic_reset[%0d]: got %b expected %b", i, cic_reset, exp); end
    end
    n_compared++;
    if (decimation !== 7'd40) begin n_mismatched++; $display("[TB] FAIL rst_decimation: got %0d expected 40", decimation); end
    ack_seen = 0;
    for (int i = 1; i <= 6; i++) begin
      idle(39);
      send_strobe(18'h00100 + 18'(i));
      if (rate_ack === 1'b1) ack_seen++;
      exp = (i < 6);
      n_compared++;
      if (out_strobe !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_suppress[%0d]: got %b expected 0", i, out_strobe); end
      n_compared++;
      if (busy !== exp) begin n_mismatched++; $display("[TB] FAIL rst_busy[%0d]: got %b expected %b", i, busy, exp); end
    end
    n_compared++;
    if (ack_seen !== 0) begin n_mismatched++; $display("[TB] FAIL rst_no_ack: got %0d acks expected 0", ack_seen); end
    idle(39);
    send_strobe(18'h2ABCD);
    n_compared++;
    if (out_strobe !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_pass_strobe: got %b expected 1", out_strobe); end
    n_compared++;
    if (out_data !== 18'h2ABCD) begin n_mismatched++; $display("[TB] FAIL rst_pass_data: got %h expected 2abcd", out_data); end
    n_compared++;
    if (decimation !== 7'd40) begin n_mismatched++; $display("[TB] FAIL rst_decimation_run: got %0d expected 40", decimation); end
    idle(1);
    n_compared++;
    if (out_strobe !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_strobe_clear: got %b expected 0", out_strobe); end
    n_compared++;
    if (out_data !== 18'h2ABCD) begin n_mismatched++; $display("[TB] FAIL rst_data_hold: got %h expected 2abcd", out_data); end
  endtask

  task automatic test_reset();
    reset = 1'b1; rate_req = 1'b0; rate_value = '0; cic_strobe = 1'b0; cic_data = '0;
    idle(2);
    n_compared++;
    if (cic_reset !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_cic_reset: got %b expected 1", cic_reset); end
    n_compared++;
    if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected 1", busy); end
    n_compared++;
    if (decimation !== 7'd40) begin n_mismatched++; $display("[TB] FAIL reset_decimation: got %0d expected 40", decimation); end
    n_compared++;
    if ({rate_ack, rate_err, out_strobe} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL reset_pulses: got %b expected 000", {rate_ack, rate_err, out_strobe}); end
    n_compared++;
    if (out_data !== 18'h0) begin n_mismatched++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
    reset_flush_sequence();
  endtask

  task automatic test_same_rate();
    send_req(7'd40, 1'b1, 18'h3FFFF);
    n_compared++;
    if (rate_ack !== 1'b1) begin n_mismatched++; $display("[TB] FAIL same_ack: got %b expected 1", rate_ack); end
    n_compared++;
    if (rate_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL same_err: got %b expected 0", rate_err); end
    n_compared++;
    if (out_strobe !== 1'b1) begin n_mismatched++; $display("[TB] FAIL same_strobe: got %b expected 1", out_strobe); end
    n_compared++;
    if (out_data !== 18'h3FFFF) begin n_mismatched++; $display("[TB] FAIL same_data: got %h expected 3ffff", out_data); end
    n_compared++;
    if ({cic_reset, busy} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL same_no_flush: got %b expected 00", {cic_reset, busy}); end
    idle(1);
    n_compared++;
    if ({rate_ack, cic_reset, busy} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL same_after: got %b expected 000", {rate_ack, cic_reset, busy}); end
  endtask

  task automatic test_restart();
    send_req(7'd10, 1'b0, '0);
    n_compared++;
    if (decimation !== 7'd10) begin n_mismatched++; $display("[TB] FAIL restart_dec10: got %0d expected 10", decimation); end
    idle(4);
    n_compared++;
    if ({cic_reset, busy} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL restart_settle1: got %b expected 01", {cic_reset, busy}); end
    ack_seen = 0;
    for (int i = 1; i <= 3; i++) begin
      idle(4);
      send_strobe(18'h01000 + 18'(i));
      if (rate_ack === 1'b1) ack_seen++;
      n_compared++;
      if (out_strobe !== 1'b0) begin n_mismatched++; $display("[TB] FAIL restart_sup_a[%0d]: got %b expected 0", i, out_strobe); end
    end
    send_req(7'd20, 1'b0, '0);
    n_compared++;
    if (decimation !== 7'd20) begin n_mismatched++; $display("[TB] FAIL restart_dec20: got %0d expected 20", decimation); end
    n_compared++;
    if (cic_reset !== 1'b1) begin n_mismatched++; $display("[TB] FAIL restart_reflush: got %b expected 1", cic_reset); end
    idle(4);
    n_compared++;
    if (cic_reset !== 1'b0) begin n_mismatched++; $display("[TB] FAIL restart_flush_end: got %b expected 0", cic_reset); end
    for (int i = 1; i <= 6; i++) begin
      idle(4);
      send_strobe(18'h02000 + 18'(i));
      if (rate_ack === 1'b1) ack_seen++;
      n_compared++;
      if (out_strobe !== 1'b0) begin n_mismatched++; $display("[TB] FAIL restart_sup_b[%0d]: got %b expected 0", i, out_strobe); end
      n_compared++;
      if (rate_ack !== (i == 6)) begin n_mismatched++; $display("[TB] FAIL restart_ack[%0d]: got %b expected %b", i, rate_ack, (i == 6)); end
    end
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (rate_ack === 1'b1) ack_seen++;
    end
    n_compared++;
    if (ack_seen !== 1) begin n_mismatched++; $display("[TB] FAIL restart_ack_count: got %0d expected 1", ack_seen); end
    idle(4);
    send_strobe(18'h12345);
    n_compared++;
    if ({out_strobe, out_data} !== {1'b1, 18'h12345}) begin n_mismatched++; $display("[TB] FAIL restart_pass: got %b/%h expected 1/12345", out_strobe, out_data); end
  endtask

  task automatic test_rate_change();
    send_req(7'd10, 1'b0, '0);
    n_compared++;
    if ({decimation, busy, cic_reset, rate_ack} !== {7'd10, 3'b110}) begin n_mismatched++; $display("[TB] FAIL change_enter: got dec=%0d busy=%b cic_reset=%b ack=%b expected 10/1/1/0", decimation, busy, cic_reset, rate_ack); end
    send_strobe(18'h0BEEF);
    n_compared++;
    if ({out_strobe, cic_reset} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL change_flush_strobe: got %b expected 01", {out_strobe, cic_reset}); end
    idle(3);
    n_compared++;
    if ({cic_reset, busy} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL change_flush_len: got %b expected 01", {cic_reset, busy}); end
    for (int i = 1; i <= 6; i++) begin
      idle(4);
      send_strobe(18'h03000 + 18'(i));
      n_compared++;
      if ({out_strobe, rate_ack} !== {1'b0, (i == 6)}) begin n_mismatched++; $display("[TB] FAIL change_settle[%0d]: got strobe=%b ack=%b expected 0/%b", i, out_strobe, rate_ack, (i == 6)); end
    end
    idle(1);
    n_compared++;
    if (rate_ack !== 1'b0) begin n_mismatched++; $display("[TB] FAIL change_ack_single: got %b expected 0", rate_ack); end
    idle(3);
    send_strobe(18'h1F00F);
    n_compared++;
    if ({out_strobe, out_data} !== {1'b1, 18'h1F00F}) begin n_mismatched++; $display("[TB] FAIL change_pass: got %b/%h expected 1/1f00f", out_strobe, out_data); end
  endtask

  task automatic test_range_err();
    logic [DW-1:0] bad [2];
    logic [OW-1:0] d;
    bad[0] = 7'd1;
    bad[1] = 7'd41;
    for (int i = 0; i < 2; i++) begin
      idle(3);
      d = 18'h0A5A5 + 18'(i);
      send_req(bad[i], 1'b1, d);
      n_compared++;
      if ({rate_err, rate_ack} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL range_err[%0d]: got err/ack %b expected 10", bad[i], {rate_err, rate_ack}); end
      n_compared++;
      if ({out_strobe, out_data} !== {1'b1, d}) begin n_mismatched++; $display("[TB] FAIL range_stream[%0d]: got %b/%h expected 1/%h", bad[i], out_strobe, out_data, d); end
      n_compared++;
      if ({decimation, busy} !== {7'd10, 1'b0}) begin n_mismatched++; $display("[TB] FAIL range_state[%0d]: got dec=%0d busy=%b expected 10/0", bad[i], decimation, busy); end
      idle(1);
      n_compared++;
      if ({rate_err, rate_ack, cic_reset} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL range_after[%0d]: got %b expected 000", bad[i], {rate_err, rate_ack, cic_reset}); end
    end
  endtask

  task automatic test_back_to_back();
    idle(3);
    send_req(7'd2, 1'b1, 18'h20000);
    n_compared++;
    if ({out_strobe, out_data} !== {1'b1, 18'h20000}) begin n_mismatched++; $display("[TB] FAIL collide_pass: got %b/%h expected 1/20000", out_strobe, out_data); end
    n_compared++;
    if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL collide_busy0: got %b expected 0", busy); end
    idle(1);
    n_compared++;
    if ({decimation, busy, cic_reset, out_strobe} !== {7'd2, 3'b110}) begin n_mismatched++; $display("[TB] FAIL collide_flush: got dec=%0d busy=%b cic_reset=%b strobe=%b expected 2/1/1/0", decimation, busy, cic_reset, out_strobe); end
    idle(4);
    n_compared++;
    if (cic_reset !== 1'b0) begin n_mismatched++; $display("[TB] FAIL collide_flush_end: got %b expected 0", cic_reset); end
    for (int i = 1; i <= 6; i++) begin
      idle(2);
      send_strobe(18'h04000 + 18'(i));
      n_compared++;
      if ({out_strobe, rate_ack} !== {1'b0, (i == 6)}) begin n_mismatched++; $display("[TB] FAIL collide_settle[%0d]: got strobe=%b ack=%b expected 0/%b", i, out_strobe, rate_ack, (i == 6)); end
    end
    idle(2);
    send_strobe(18'h00001);
    n_compared++;
    if ({out_strobe, out_data} !== {1'b1, 18'h00001}) begin n_mismatched++; $display("[TB] FAIL collide_resume: got %b/%h expected 1/00001", out_strobe, out_data); end
  endtask

  task automatic test_reset_mid();
    idle(2);
    send_req(7'd8, 1'b0, '0);
    n_compared++;
    if ({decimation, cic_reset} !== {7'd8, 1'b1}) begin n_mismatched++; $display("[TB] FAIL mid_enter: got dec=%0d cic_reset=%b expected 8/1", decimation, cic_reset); end
    idle(1);
    reset = 1'b1;
    idle(1);
    n_compared++;
    if ({decimation, cic_reset, busy, rate_ack} !== {7'd40, 3'b110}) begin n_mismatched++; $display("[TB] FAIL mid_reset: got dec=%0d cic_reset=%b busy=%b ack=%b expected 40/1/1/0", decimation, cic_reset, busy, rate_ack); end
    reset_flush_sequence();
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    ack_seen     = 0;
    test_reset();
    test_same_rate();
    test_restart();
    test_rate_change();
    test_range_err();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/cic_rate_ctrl.md
Name: cic_rate_ctrl

Overview:
Run-time controller for one CIC decimator instance. It accepts sample-rate change requests from the host/command path and range-checks them. It sequences a safe reconfiguration: a synchronous CIC flush, a decimation load, then settle suppression of outputs. Sits between the command decoder and the CIC, and also gates and registers the CIC output stream towards the downstream FIR.

Parameters:
STAGES, 5, CIC stage count; sets the number of output samples discarded after a rate change
MIN_DECIMATION, 2, smallest legal decimation
MAX_DECIMATION, 40, largest legal decimation
DEFAULT_DECIMATION, 40, decimation loaded at reset
FLUSH_CYCLES, 4, clocks the CIC reset is held during a flush (>=1)
OUT_WIDTH, 18, CIC output sample width
DW, $clog2(MAX_DECIMATION)+1, decimation bus width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
rate_req  in  1  single-cycle request strobe
rate_value  in  DW  requested decimation, sampled when rate_req=1
rate_ack  out  1  one-cycle pulse when a request has completed (rate in force, outputs valid again)
rate_err  out  1  one-cycle pulse when a request is rejected (out of range)
decimation  out  DW  decimation driven to the CIC
cic_reset  out  1  synchronous flush to the CIC
cic_strobe  in  1  CIC out_strobe
cic_data  in  OUT_WIDTH  CIC out_data (signed)
out_strobe  out  1  gated output strobe
out_data  out  OUT_WIDTH  registered output sample (signed)
busy  out  1  high in FLUSH or SETTLE

Behaviour:
- Reset values (asynchronous):
  - state=FLUSH, flush counter=0, settle counter=0
  - decimation=DEFAULT_DECIMATION, cic_reset=1, busy=1
  - rate_ack=0, rate_err=0, out_strobe=0, out_data=0
  - pending flag=0; no ack is issued for the reset-initiated flush.
- States: RUN, FLUSH, SETTLE.
- FLUSH:
  - cic_reset=1 for exactly FLUSH_CYCLES clocks, counted by the flush counter.
  - Then -> SETTLE with the settle counter cleared.
  - decimation is updated on the clock edge entering FLUSH, so it is stable for the whole flush.
- SETTLE:
  - cic_reset=0. Each cic_strobe increments the settle counter and is suppressed (out_strobe=0).
  - When the (STAGES+1)th strobe arrives (counter reaches STAGES, 0-based), -> RUN. That strobe is also suppressed.
  - rate_ack pulses on the transition to RUN if the pending flag is set; the flag is then cleared.
- RUN:
  - On cic_strobe: out_data<=cic_data and out_strobe=1 on the next clock (1-cycle latency).
  - out_data holds its value between strobes.
- Request handling (rate_req=1, any state):
  - Range check: rate_value<MIN_DECIMATION or >MAX_DECIMATION -> rate_err pulses the next cycle; state, decimation and pending flag are unchanged.
  - In RUN with rate_value==decimation: rate_ack pulses the next cycle; no flush.
  - Otherwise, for a legal value: decimation<=rate_value, pending flag<=1, state<=FLUSH, flush counter cleared.
  - A legal request arriving in FLUSH or SETTLE restarts the flush; the last request wins, and only one ack is issued.
  - In FLUSH/SETTLE, a legal request equal to the current decimation still restarts the flush.
- Simultaneous events:
  - rate_req with cic_strobe in RUN: that strobe still passes to the output; the flush begins the next cycle.
  - cic_strobe during FLUSH is ignored and not counted.
- out_strobe is never 1 while busy=1.
- rate_ack and rate_err are never both 1.
- Reset asserted mid-sequence: the pending request is dropped without ack, and decimation returns to DEFAULT_DECIMATION.
- No arithmetic on data: samples are passed bit-exact.

Test Plan:
- Reset release, cic_strobe every 40 clocks:
  - cic_reset high for 4 clocks after reset deasserts.
  - The first 6 strobes are suppressed with no rate_ack.
  - The 7th strobe appears on out_strobe one cycle later with the data equal.
  - decimation=40 throughout.
- In RUN, rate_req with rate_value=10:
  - decimation=10 on the next edge, busy=1, cic_reset high for 4 clocks.
  - 6 strobes are suppressed, then one rate_ack pulse, and the next strobe passes.
- rate_value=1 and rate_value=41 (on separate requests): each produces one rate_err pulse; decimation, state and the output stream are unchanged.
- In RUN, rate_value equal to the current decimation (40): rate_ack the next cycle, cic_reset stays 0, no strobe lost.
- Request 10, then during SETTLE (after 3 strobes) request 20:
  - The flush restarts and decimation=20.
  - 6 further strobes are suppressed, then exactly one rate_ack.
- Assert reset during FLUSH of a pending request to 8: decimation returns to 40, no rate_ack, and the reset-flush sequence is as in scenario 1.
